// File: rtl/genie_merge_arb_pkg.sv
// Shared types and the round-robin scan helper for genie_merge_arb.
package genie_merge_arb_pkg;

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  // Widest input count the scan helper supports; must stay 32 (index slices below use [4:0]).
  localparam int MaxNi = 32;

  // Returns the first set bit of valid[0 +: n] scanning last+1, last+2, ... modulo n,
  // or -1 when nothing in range is set. last must be < n.
  function automatic int rr_pick(input logic [MaxNi-1:0] valid, input int n, input int last);
    int idx;
    rr_pick = -1;
    for (int k = 1; k <= MaxNi; k++) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (rr_pick < 0 && valid[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/genie_rr_arb.sv
// Combinational round-robin picker: lowest-distance requester after last_idx_i wins.
module genie_rr_arb
  import genie_merge_arb_pkg::*;
#(
  parameter int unsigned NI = 2,
  localparam int unsigned IW = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic [NI-1:0] req_i,
  input  logic [IW-1:0] last_idx_i,
  output logic [NI-1:0] gnt_onehot_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [MaxNi-1:0] req_ext;
  int               pick;

  // Scan from the input after the last winner, wrapping at NI-1.
  always_comb begin
    req_ext      = MaxNi'(req_i);
    pick         = rr_pick(req_ext, int'(NI), int'(last_idx_i));
    any_o        = (pick >= 0);
    gnt_idx_o    = any_o ? IW'(pick) : '0;
    gnt_onehot_o = '0;
    if (any_o) gnt_onehot_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/genie_merge_arb.sv
// Packet-aware round-robin merge of NI valid/ready streams onto one output.
// A packet locks the grant from its first beat to its EOP beat; priority then rotates.
// Optional output register stage: define GENIE_MERGE_ARB_OREG_EN.
module genie_merge_arb
  import genie_merge_arb_pkg::*;
#(
  parameter int unsigned NI    = 2,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned DW   = (WIDTH > 0) ? WIDTH : 1,
  localparam int unsigned DIN  = (NI * WIDTH > 0) ? NI * WIDTH : 1,
  localparam int unsigned IW   = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DIN-1:0] i_data,
  input  logic [NI-1:0]  i_valid,
  output logic [NI-1:0]  o_ready,
  input  logic [NI-1:0]  i_eop,
  output logic           o_valid,
  output logic [DW-1:0]  o_data,
  input  logic           i_ready,
  output logic           o_eop,
  output logic [NI-1:0]  o_grant
);

  if (NI < 2 || NI > MaxNi) begin : g_bad_ni
    $error("genie_merge_arb: NI must be in 2..32");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;

  logic [NI-1:0] pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  logic [IW-1:0] g;
  logic          grant_vld;
  logic [NI-1:0] grant_onehot;
  logic          up_valid, up_ready, up_xfer, sel_eop;
  logic [DW-1:0] sel_data;

  genie_rr_arb #(
    .NI(NI)
  ) u_rr (
    .req_i        (i_valid),
    .last_idx_i   (last_idx_q),
    .gnt_onehot_o (pick_onehot),
    .gnt_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  // Grant selection: held lock wins, otherwise the round-robin pick; nothing granted in reset.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      g         = lock_idx_q;
      grant_vld = !reset;
    end else begin
      g         = pick_idx;
      grant_vld = pick_any && !reset;
    end
    grant_onehot = '0;
    if (grant_vld) grant_onehot[g] = 1'b1;
    up_valid = grant_vld && i_valid[g];
    sel_eop  = grant_vld && i_eop[g];
    up_xfer  = up_valid && up_ready;
    o_ready  = grant_onehot & {NI{up_ready}};
    o_grant  = grant_onehot;
  end

  // Payload mux; ungranted inputs never reach the output.
  if (WIDTH > 0) begin : g_data
    assign sel_data = grant_vld ? i_data[g*WIDTH +: WIDTH] : '0;
  end else begin : g_nodata
    assign sel_data = '0;
  end

  // Lock on a non-EOP beat, release and rotate priority on the EOP beat.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    last_idx_d = last_idx_q;
    if (up_xfer) begin
      if (sel_eop) begin
        state_d    = ST_IDLE;
        last_idx_d = g;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = g;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      last_idx_q <= IW'(NI - 1);
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

`ifdef GENIE_MERGE_ARB_OREG_EN
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_eop_q, out_eop_d;

  // Output stage accepts a new beat whenever it is empty or being drained.
  always_comb begin
    up_ready    = !out_valid_q || i_ready;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eop_d   = out_eop_q;
    if (up_ready) begin
      out_valid_d = up_valid;
      out_data_d  = sel_data;
      out_eop_d   = up_valid && sel_eop;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eop_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_eop   = out_eop_q;
`else
  // Zero-latency datapath straight from the mux.
  always_comb begin
    up_ready = i_ready;
    o_valid  = up_valid;
    o_data   = sel_data;
    o_eop    = sel_eop;
  end
`endif

endmodule

// File: tb/tb_genie_merge_arb.sv
// Directed table-driven bench for genie_merge_arb (NI=3, WIDTH=8, combinational datapath).
module tb_genie_merge_arb;

  localparam int NI = 3;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NI*W-1:0] i_data;
  logic [NI-1:0] i_valid, i_eop, o_ready, o_grant;
  logic          i_ready, o_valid, o_eop;
  logic [W-1:0]  o_data;

  genie_merge_arb #(
    .NI    (NI),
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_eop   (i_eop),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_eop   (o_eop),
    .o_grant (o_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  eop;
    logic        rdy;
    logic [23:0] data;
    logic [2:0]  x_ready;
    logic        x_valid;
    logic [7:0]  x_data;
    logic        x_eop;
    logic [2:0]  x_grant;
  } vec_t;

  localparam int NV = 23;
  vec_t tab[NV];
  int   nv = 0;
  int   total = 0;
  int   bad = 0;

  task automatic add(input logic [2:0] v, input logic [2:0] e, input logic r,
                     input logic [23:0] d, input logic [2:0] xr, input logic xv,
                     input logic [7:0] xd, input logic xe, input logic [2:0] xg);
    tab[nv].valid   = v;
    tab[nv].eop     = e;
    tab[nv].rdy     = r;
    tab[nv].data    = d;
    tab[nv].x_ready = xr;
    tab[nv].x_valid = xv;
    tab[nv].x_data  = xd;
    tab[nv].x_eop   = xe;
    tab[nv].x_grant = xg;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] xr, input logic xv,
                         input logic [7:0] xd, input logic xe, input logic [2:0] xg);
    chk({tag, " o_ready"}, 32'(o_ready), 32'(xr));
    chk({tag, " o_valid"}, 32'(o_valid), 32'(xv));
    chk({tag, " o_data"},  32'(o_data),  32'(xd));
    chk({tag, " o_eop"},   32'(o_eop),   32'(xe));
    chk({tag, " o_grant"}, 32'(o_grant), 32'(xg));
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] e, input logic r,
                       input logic [23:0] d);
    i_valid = v;
    i_eop   = e;
    i_ready = r;
    i_data  = d;
  endtask

  initial begin
    // All inputs offering single-beat packets: strict rotation 0,1,2,...
    add(3'b111, 3'b111, 1'b1, 24'hC2B1A0, 3'b001, 1'b1, 8'hA0, 1'b1, 3'b001);
    add(3'b111, 3'b111, 1'b1, 24'hC2B1A0, 3'b010, 1'b1, 8'hB1, 1'b1, 3'b010);
    add(3'b111, 3'b111, 1'b1, 24'hC2B1A0, 3'b100, 1'b1, 8'hC2, 1'b1, 3'b100);
    add(3'b111, 3'b111, 1'b1, 24'hC2B1A0, 3'b001, 1'b1, 8'hA0, 1'b1, 3'b001);
    add(3'b111, 3'b111, 1'b1, 24'hC2B1A0, 3'b010, 1'b1, 8'hB1, 1'b1, 3'b010);
    add(3'b111, 3'b111, 1'b1, 24'hC2B1A0, 3'b100, 1'b1, 8'hC2, 1'b1, 3'b100);
    // Downstream stall 5 cycles with in0,in2 valid: grant stays on in0, nothing moves.
    for (int k = 0; k < 5; k++)
      add(3'b101, 3'b101, 1'b0, 24'hC2B1A0, 3'b000, 1'b1, 8'hA0, 1'b1, 3'b001);
    add(3'b101, 3'b101, 1'b1, 24'hC2B1A0, 3'b001, 1'b1, 8'hA0, 1'b1, 3'b001);
    add(3'b101, 3'b101, 1'b1, 24'hC2B1A0, 3'b100, 1'b1, 8'hC2, 1'b1, 3'b100);
    // in0 4-beat packet while in1 waits; in1 follows immediately.
    add(3'b011, 3'b000, 1'b1, 24'hC22010, 3'b001, 1'b1, 8'h10, 1'b0, 3'b001);
    add(3'b011, 3'b000, 1'b1, 24'hC22011, 3'b001, 1'b1, 8'h11, 1'b0, 3'b001);
    add(3'b011, 3'b000, 1'b1, 24'hC22012, 3'b001, 1'b1, 8'h12, 1'b0, 3'b001);
    add(3'b011, 3'b001, 1'b1, 24'hC22013, 3'b001, 1'b1, 8'h13, 1'b1, 3'b001);
    add(3'b010, 3'b000, 1'b1, 24'hC22010, 3'b010, 1'b1, 8'h20, 1'b0, 3'b010);
    // Locked in1 bubbles for 2 cycles while in0 is valid: grant held, no transfer.
    add(3'b001, 3'b000, 1'b1, 24'hC22010, 3'b010, 1'b0, 8'h20, 1'b0, 3'b010);
    add(3'b001, 3'b000, 1'b1, 24'hC22010, 3'b010, 1'b0, 8'h20, 1'b0, 3'b010);
    add(3'b011, 3'b010, 1'b1, 24'hC22110, 3'b010, 1'b1, 8'h21, 1'b1, 3'b010);
    add(3'b001, 3'b001, 1'b1, 24'hC2B1A0, 3'b001, 1'b1, 8'hA0, 1'b1, 3'b001);
    // EOP without valid is ignored; nothing granted.
    add(3'b000, 3'b111, 1'b1, 24'hC2B1A0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);

    // Outputs are forced low while reset is held, even with all inputs valid.
    drive(3'b111, 3'b111, 1'b1, 24'hC2B1A0);
    #3;
    chk_all("reset", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < nv; i++) begin
      drive(tab[i].valid, tab[i].eop, tab[i].rdy, tab[i].data);
      #1;
      chk_all($sformatf("v%0d", i), tab[i].x_ready, tab[i].x_valid, tab[i].x_data,
              tab[i].x_eop, tab[i].x_grant);
      @(negedge clk);
    end

    // Lock onto in2 (priority is after in0 here), then reset mid-packet.
    drive(3'b100, 3'b000, 1'b1, 24'hC2B1A0);
    #1;
    chk_all("lock2 b1", 3'b100, 1'b1, 8'hC2, 1'b0, 3'b100);
    @(negedge clk);
    drive(3'b111, 3'b000, 1'b1, 24'hC2B1A0);
    #1;
    chk_all("lock2 b2", 3'b100, 1'b1, 8'hC2, 1'b0, 3'b100);
    #1;
    reset = 1'b1;
    #1;
    chk_all("midreset", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    drive(3'b111, 3'b111, 1'b1, 24'hC2B1A0);
    #1;
    chk_all("post reset p0", 3'b001, 1'b1, 8'hA0, 1'b1, 3'b001);
    @(negedge clk);
    #1;
    chk_all("post reset p1", 3'b010, 1'b1, 8'hB1, 1'b1, 3'b010);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
